// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : alu_pkg                                                  |
// | Description : Shared constants for the ALU issue/retire front end.     |
// |               Holds the 4-bit ALU op codes, the R-type funct and       |
// |               I-type opcode values, the 2-bit alu_op_type encoding,    |
// |               the per-stage occupancy state and the decoder output.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package alu_pkg;

   // ALU operation codes
   localparam logic [3:0] ALU_LUI = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_SLL = 4'b0010;
   localparam logic [3:0] ALU_ADD = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0101;
   localparam logic [3:0] ALU_AND = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b0111;
   localparam logic [3:0] ALU_ILL = 4'b1111;

   // R-type funct field values
   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_ADD  = 6'h20;
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUB  = 6'h22;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;

   // I-type opcode field values
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ADDIU = 6'h09;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_LUI   = 6'h0F;

   // alu_op_type encoding from the main decoder
   typedef enum logic [1:0] {
      OP_TYPE_MEM    = 2'b00,   // lw/sw address add
      OP_TYPE_BRANCH = 2'b01,   // beq/bne compare
      OP_TYPE_RTYPE  = 2'b10,   // decode by funct
      OP_TYPE_ITYPE  = 2'b11    // decode by opcode
   } alu_op_type_e;

   // Occupancy of one pipeline stage
   typedef enum logic {
      STAGE_EMPTY = 1'b0,
      STAGE_FULL  = 1'b1
   } stage_state_e;

   // Decoder result
   typedef struct packed {
      logic [3:0] op;
      logic       illegal;
   } alu_dec_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_encoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : alu_op_encoder                                           |
// | Description : Combinational decode of {alu_op_type, funct, opcode}     |
// |               into the 4-bit ALU operation code plus an illegal flag.  |
// |               Macro ALU_ISSUE_ILLEGAL_EN: when defined, unknown        |
// |               funct/opcode values yield ALU_ILL with illegal = 1;      |
// |               otherwise they fall back to ALU_ADD with illegal = 0.    |
// | Ports       : alu_op_type_i [1:0] - operation class                    |
// |               funct_i       [5:0] - R-type funct field                 |
// |               opcode_i      [5:0] - I-type opcode field                |
// |               dec_o               - {op code, illegal}                 |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module alu_op_encoder
   import alu_pkg::*;
(
   input  logic [1:0] alu_op_type_i,
   input  logic [5:0] funct_i,
   input  logic [5:0] opcode_i,
   output alu_dec_t   dec_o
);

   // Result used for any funct/opcode the decoder does not recognise
`ifdef ALU_ISSUE_ILLEGAL_EN
   localparam alu_dec_t UNKNOWN_DEC = '{op: ALU_ILL, illegal: 1'b1};
`else
   localparam alu_dec_t UNKNOWN_DEC = '{op: ALU_ADD, illegal: 1'b0};
`endif

   alu_dec_t funct_dec;
   alu_dec_t opcode_dec;

   always_comb begin
      funct_dec = UNKNOWN_DEC;
      unique case (funct_i)
         FUNCT_ADD, FUNCT_ADDU: funct_dec = '{op: ALU_ADD, illegal: 1'b0};
         FUNCT_SUB, FUNCT_SUBU: funct_dec = '{op: ALU_SUB, illegal: 1'b0};
         FUNCT_AND:             funct_dec = '{op: ALU_AND, illegal: 1'b0};
         FUNCT_OR:              funct_dec = '{op: ALU_OR,  illegal: 1'b0};
         FUNCT_NOR:             funct_dec = '{op: ALU_NOR, illegal: 1'b0};
         FUNCT_SLL:             funct_dec = '{op: ALU_SLL, illegal: 1'b0};
         FUNCT_SRL:             funct_dec = '{op: ALU_SRL, illegal: 1'b0};
         default:               funct_dec = UNKNOWN_DEC;
      endcase
   end

   always_comb begin
      opcode_dec = UNKNOWN_DEC;
      unique case (opcode_i)
         OPC_ADDI, OPC_ADDIU: opcode_dec = '{op: ALU_ADD, illegal: 1'b0};
         OPC_ANDI:            opcode_dec = '{op: ALU_AND, illegal: 1'b0};
         OPC_ORI:             opcode_dec = '{op: ALU_OR,  illegal: 1'b0};
         OPC_LUI:             opcode_dec = '{op: ALU_LUI, illegal: 1'b0};
         default:             opcode_dec = UNKNOWN_DEC;
      endcase
   end

   // Memory and branch classes are fixed operations and never illegal
   always_comb begin
      dec_o = '{op: ALU_ADD, illegal: 1'b0};
      unique case (alu_op_type_e'(alu_op_type_i))
         OP_TYPE_MEM:    dec_o = '{op: ALU_ADD, illegal: 1'b0};
         OP_TYPE_BRANCH: dec_o = '{op: ALU_SUB, illegal: 1'b0};
         OP_TYPE_RTYPE:  dec_o = funct_dec;
         OP_TYPE_ITYPE:  dec_o = opcode_dec;
         default:        dec_o = '{op: ALU_ADD, illegal: 1'b0};
      endcase
   end

endmodule : alu_op_encoder
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : alu_issue                                                |
// | Description : Two-stage issue/retire front end for the 32-bit ALU.     |
// |               S1 registers the encoded op and operands that drive the  |
// |               combinational ALU; S2 captures the ALU result, zero flag |
// |               and illegal flag behind a valid/ready handshake.         |
// |               Macro ALU_ISSUE_ILLEGAL_EN enables illegal-decode        |
// |               reporting (see alu_op_encoder); when undefined,          |
// |               illegal_o is always 0.                                   |
// | Ports       : clk, reset (sync, active-high)                           |
// |               in_valid_i/in_ready_o   - instruction handshake          |
// |               alu_op_type_i, funct_i, opcode_i - decode fields         |
// |               rs_data_i, rt_data_i, imm_i, shamt_i, alu_src_i          |
// |               alu_operation_o, alu_a_o, alu_b_o, alu_shamt_o - to ALU  |
// |               alu_data_i, alu_zero_i  - from ALU                       |
// |               out_valid_o/out_ready_i - result handshake               |
// |               result_o, zero_o, illegal_o - captured result            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module alu_issue
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   // decode side
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [1:0]  alu_op_type_i,
   input  logic [5:0]  funct_i,
   input  logic [5:0]  opcode_i,
   input  logic [31:0] rs_data_i,
   input  logic [31:0] rt_data_i,
   input  logic [31:0] imm_i,
   input  logic [4:0]  shamt_i,
   input  logic        alu_src_i,
   // ALU drive
   output logic [3:0]  alu_operation_o,
   output logic [31:0] alu_a_o,
   output logic [31:0] alu_b_o,
   output logic [4:0]  alu_shamt_o,
   // ALU return
   input  logic [31:0] alu_data_i,
   input  logic        alu_zero_i,
   // result side
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] result_o,
   output logic        zero_o,
   output logic        illegal_o
);

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   alu_dec_t dec;

   alu_op_encoder u_alu_op_encoder (
      .alu_op_type_i (alu_op_type_i),
      .funct_i       (funct_i),
      .opcode_i      (opcode_i),
      .dec_o         (dec)
   );

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   stage_state_e s1_state_q, s1_state_d;
   stage_state_e s2_state_q, s2_state_d;

   logic [3:0]  op_q,      op_d;
   logic [31:0] a_q,       a_d;
   logic [31:0] b_q,       b_d;
   logic [4:0]  shamt_q,   shamt_d;
   logic        s1_ill_q,  s1_ill_d;

   logic [31:0] result_q,  result_d;
   logic        zero_q,    zero_d;
   logic        illegal_q, illegal_d;

   logic s1_full;
   logic s2_full;
   logic s1_adv;
   logic accept;

   // ------------------------------------------------------------------
   // Handshake. in_ready_o depends on out_ready_i through s1_adv but
   // never on in_valid_i.
   // ------------------------------------------------------------------
   always_comb begin
      s1_full    = (s1_state_q == STAGE_FULL);
      s2_full    = (s2_state_q == STAGE_FULL);
      s1_adv     = s1_full & (~s2_full | out_ready_i);
      in_ready_o = ~s1_full | s1_adv;
      accept     = in_valid_i & in_ready_o;
   end

   // ------------------------------------------------------------------
   // Next-state logic for both stages
   // ------------------------------------------------------------------
   always_comb begin
      s1_state_d = s1_state_q;
      s2_state_d = s2_state_q;

      // S1: a new accept keeps it full even while the old entry leaves
      if (accept) begin
         s1_state_d = STAGE_FULL;
      end else if (s1_adv) begin
         s1_state_d = STAGE_EMPTY;
      end

      // S2: a load in the same cycle as a retire wins, so valid stays high
      if (s1_adv) begin
         s2_state_d = STAGE_FULL;
      end else if (out_ready_i) begin
         s2_state_d = STAGE_EMPTY;
      end
   end

   // ------------------------------------------------------------------
   // Datapath next values. Registers hold unless loaded, which keeps the
   // ALU drive and the result stable while their stage is stalled.
   // ------------------------------------------------------------------
   always_comb begin
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      shamt_d   = shamt_q;
      s1_ill_d  = s1_ill_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;

      if (accept) begin
         op_d     = dec.op;
         a_d      = rs_data_i;
         b_d      = alu_src_i ? imm_i : rt_data_i;
         shamt_d  = shamt_i;
         s1_ill_d = dec.illegal;
      end

      // S1 illegal bit is constant 0 when illegal detection is disabled
      if (s1_adv) begin
         result_d  = s1_ill_q ? 32'd0 : alu_data_i;
         zero_d    = alu_zero_i;
         illegal_d = s1_ill_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_state_q <= STAGE_EMPTY;
         s2_state_q <= STAGE_EMPTY;
         op_q       <= ALU_ILL;
         a_q        <= 32'd0;
         b_q        <= 32'd0;
         shamt_q    <= 5'd0;
         s1_ill_q   <= 1'b0;
         result_q   <= 32'd0;
         zero_q     <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         s1_state_q <= s1_state_d;
         s2_state_q <= s2_state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         shamt_q    <= shamt_d;
         s1_ill_q   <= s1_ill_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         illegal_q  <= illegal_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign alu_operation_o = op_q;
   assign alu_a_o         = a_q;
   assign alu_b_o         = b_q;
   assign alu_shamt_o     = shamt_q;
   assign out_valid_o     = s2_full;
   assign result_o        = result_q;
   assign zero_o          = zero_q;
   assign illegal_o       = illegal_q;

endmodule : alu_issue
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_alu_issue                                             |
// | Description : Self-checking bench for alu_issue. Contains a behavioural|
// |               32-bit ALU driven by the DUT and a scoreboard of results |
// |               computed directly from the instruction fields.           |
// |               Honors ALU_ISSUE_ILLEGAL_EN for the illegal behaviour.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_alu_issue;

   logic        clk;
   logic        reset;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [1:0]  alu_op_type_i;
   logic [5:0]  funct_i;
   logic [5:0]  opcode_i;
   logic [31:0] rs_data_i;
   logic [31:0] rt_data_i;
   logic [31:0] imm_i;
   logic [4:0]  shamt_i;
   logic        alu_src_i;
   logic [3:0]  alu_operation_o;
   logic [31:0] alu_a_o;
   logic [31:0] alu_b_o;
   logic [4:0]  alu_shamt_o;
   logic [31:0] alu_data_i;
   logic        alu_zero_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] result_o;
   logic        zero_o;
   logic        illegal_o;

   alu_issue dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid_i      (in_valid_i),
      .in_ready_o      (in_ready_o),
      .alu_op_type_i   (alu_op_type_i),
      .funct_i         (funct_i),
      .opcode_i        (opcode_i),
      .rs_data_i       (rs_data_i),
      .rt_data_i       (rt_data_i),
      .imm_i           (imm_i),
      .shamt_i         (shamt_i),
      .alu_src_i       (alu_src_i),
      .alu_operation_o (alu_operation_o),
      .alu_a_o         (alu_a_o),
      .alu_b_o         (alu_b_o),
      .alu_shamt_o     (alu_shamt_o),
      .alu_data_i      (alu_data_i),
      .alu_zero_i      (alu_zero_i),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .result_o        (result_o),
      .zero_o          (zero_o),
      .illegal_o       (illegal_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU attached to the DUT drive outputs
   always_comb begin
      alu_data_i = 32'd0;
      case (alu_operation_o)
         4'b0011: alu_data_i = alu_a_o + alu_b_o;
         4'b0101: alu_data_i = alu_a_o - alu_b_o;
         4'b0000: alu_data_i = alu_b_o << 16;
         4'b0001: alu_data_i = alu_a_o | alu_b_o;
         4'b0010: alu_data_i = alu_b_o << alu_shamt_o;
         4'b0100: alu_data_i = alu_b_o >> alu_shamt_o;
         4'b0110: alu_data_i = alu_a_o & alu_b_o;
         4'b0111: alu_data_i = ~(alu_a_o | alu_b_o);
         default: alu_data_i = 32'd0;
      endcase
      alu_zero_i = (alu_operation_o == 4'b1111) ? 1'b1 : (alu_data_i == 32'd0);
   end

   typedef struct {
      logic [31:0] result;
      logic        zero;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

`ifdef ALU_ISSUE_ILLEGAL_EN
   localparam bit ILL_EN = 1'b1;
`else
   localparam bit ILL_EN = 1'b0;
`endif

   // Reference: what the instruction should produce, {illegal, op, result}
   task automatic reference(input logic [1:0] ty, input logic [5:0] fn, input logic [5:0] opc,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                            output logic ill, output logic [3:0] op, output logic [31:0] res);
      bit known;
      known = 1'b1;
      ill   = 1'b0;
      op    = 4'b0011;
      res   = a + b;
      if (ty == 2'b01) begin
         op = 4'b0101; res = a - b;
      end else if (ty == 2'b10) begin
         if (fn == 6'h20 || fn == 6'h21)      begin op = 4'b0011; res = a + b; end
         else if (fn == 6'h22 || fn == 6'h23) begin op = 4'b0101; res = a - b; end
         else if (fn == 6'h24) begin op = 4'b0110; res = a & b; end
         else if (fn == 6'h25) begin op = 4'b0001; res = a | b; end
         else if (fn == 6'h27) begin op = 4'b0111; res = ~(a | b); end
         else if (fn == 6'h00) begin op = 4'b0010; res = b << sh; end
         else if (fn == 6'h02) begin op = 4'b0100; res = b >> sh; end
         else known = 1'b0;
      end else if (ty == 2'b11) begin
         if (opc == 6'h08 || opc == 6'h09) begin op = 4'b0011; res = a + b; end
         else if (opc == 6'h0C) begin op = 4'b0110; res = a & b; end
         else if (opc == 6'h0D) begin op = 4'b0001; res = a | b; end
         else if (opc == 6'h0F) begin op = 4'b0000; res = {b[15:0], 16'h0000}; end
         else known = 1'b0;
      end
      if (!known) begin
         if (ILL_EN) begin
            ill = 1'b1; op = 4'b1111; res = 32'd0;
         end else begin
            op = 4'b0011; res = a + b;
         end
      end
   endtask

   // One clock cycle: retire/accept bookkeeping around the rising edge.
   // Called right after inputs are driven following a falling edge.
   task automatic tick(output bit acc, output bit ret);
      exp_t        e;
      logic        ill;
      logic [3:0]  op;
      logic [31:0] res;
      logic [31:0] b;
      #1;
      acc = in_valid_i && in_ready_o;
      ret = out_valid_o && out_ready_i;
      if (ret) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", {31'd0, out_valid_o}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("retire_result",  result_o, e.result);
            check("retire_zero",    {31'd0, zero_o}, {31'd0, e.zero});
            check("retire_illegal", {31'd0, illegal_o}, {31'd0, e.ill});
         end
      end
      b = alu_src_i ? imm_i : rt_data_i;
      reference(alu_op_type_i, funct_i, opcode_i, rs_data_i, b, shamt_i, ill, op, res);
      @(posedge clk);
      #1;
      if (acc) begin
         e.result = res;
         e.zero   = (res == 32'd0);
         e.ill    = ill;
         sb.push_back(e);
         check("issue_op",    {28'd0, alu_operation_o}, {28'd0, op});
         check("issue_a",     alu_a_o, rs_data_i);
         check("issue_b",     alu_b_o, b);
         check("issue_shamt", {27'd0, alu_shamt_o}, {27'd0, shamt_i});
      end
      @(negedge clk);
   endtask

   task automatic set_instr(input logic [1:0] ty, input logic [5:0] fn, input logic [5:0] opc,
                            input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                            input logic [4:0] sh, input logic src);
      in_valid_i    = 1'b1;
      alu_op_type_i = ty;
      funct_i       = fn;
      opcode_i      = opc;
      rs_data_i     = rs;
      rt_data_i     = rt;
      imm_i         = imm;
      shamt_i       = sh;
      alu_src_i     = src;
   endtask

   task automatic rand_instr();
      logic [5:0] fl [10];
      logic [5:0] ol [6];
      logic [5:0] fn;
      logic [5:0] opc;
      fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h3F};
      ol = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23};
      fn  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fl[$urandom_range(0, 9)];
      opc = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ol[$urandom_range(0, 5)];
      set_instr(2'($urandom), fn, opc,
                ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                $urandom, 5'($urandom), 1'($urandom));
   endtask

   task automatic do_reset(input int n);
      reset       = 1'b1;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      sb.delete();
   endtask

   initial begin
      bit          acc, ret;
      int          accepted, retired, cyc;
      logic [31:0] held;

      reset = 1'b0;
      in_valid_i = 1'b0; out_ready_i = 1'b0;
      set_instr(2'b00, 6'h0, 6'h0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
      in_valid_i = 1'b0;
      @(negedge clk);

      // Reset state
      do_reset(2);
      #1;
      check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
      check("rst_in_ready",  {31'd0, in_ready_o}, 32'd1);
      check("rst_op",        {28'd0, alu_operation_o}, 32'hF);
      check("rst_a",         alu_a_o, 32'd0);
      check("rst_b",         alu_b_o, 32'd0);
      check("rst_shamt",     {27'd0, alu_shamt_o}, 32'd0);
      check("rst_result",    result_o, 32'd0);
      check("rst_zero",      {31'd0, zero_o}, 32'd0);
      check("rst_illegal",   {31'd0, illegal_o}, 32'd0);
      @(negedge clk);

      // R-type add: 5 + 7
      out_ready_i = 1'b1;
      set_instr(2'b10, 6'h20, 6'h00, 32'd5, 32'd7, 32'd99, 5'd0, 1'b0);
      tick(acc, ret);
      in_valid_i = 1'b0;
      tick(acc, ret);
      check("add_valid",  {31'd0, out_valid_o}, 32'd1);
      check("add_result", result_o, 32'd12);
      check("add_zero",   {31'd0, zero_o}, 32'd0);
      tick(acc, ret);

      // Branch compare, equal operands
      set_instr(2'b01, 6'h3F, 6'h3F, 32'h1234, 32'h1234, 32'd1, 5'd0, 1'b0);
      tick(acc, ret);
      in_valid_i = 1'b0;
      tick(acc, ret);
      check("beq_zero",   {31'd0, zero_o}, 32'd1);
      check("beq_result", result_o, 32'd0);
      tick(acc, ret);

      // LUI
      set_instr(2'b11, 6'h00, 6'h0F, 32'h5555, 32'h7777, 32'h0000ABCD, 5'd3, 1'b1);
      tick(acc, ret);
      in_valid_i = 1'b0;
      tick(acc, ret);
      check("lui_result", result_o, 32'hABCD0000);
      tick(acc, ret);

      // Shift left by the maximum amount
      set_instr(2'b10, 6'h00, 6'h00, 32'hFFFF, 32'd1, 32'd0, 5'd31, 1'b0);
      tick(acc, ret);
      in_valid_i = 1'b0;
      tick(acc, ret);
      check("sll_result", result_o, 32'h80000000);
      tick(acc, ret);

      // Illegal funct
      set_instr(2'b10, 6'h3F, 6'h00, 32'd3, 32'd4, 32'd0, 5'd0, 1'b0);
      tick(acc, ret);
      in_valid_i = 1'b0;
      tick(acc, ret);
      check("ill_flag",   {31'd0, illegal_o}, ILL_EN ? 32'd1 : 32'd0);
      check("ill_result", result_o, ILL_EN ? 32'd0 : 32'd7);
      tick(acc, ret);

      // Backpressure: four ops against a stalled consumer
      out_ready_i = 1'b0;
      accepted = 0;
      rand_instr();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) held = result_o;
         tick(acc, ret);
         if (acc) begin accepted++; rand_instr(); end
      end
      check("bp_accepts",  accepted, 32'd2);
      check("bp_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("bp_hold",     result_o, held);
      out_ready_i = 1'b1;
      retired = 0;
      cyc = 0;
      while ((accepted < 4 || sb.size() != 0) && cyc < 20) begin
         if (accepted >= 4) in_valid_i = 1'b0;
         tick(acc, ret);
         if (acc) begin accepted++; if (accepted < 4) rand_instr(); end
         if (ret) retired++;
         cyc++;
      end
      check("bp_drain_retired", retired, 32'd4);
      check("bp_drain_cycles",  cyc, 32'd4);

      // Reset with both stages full
      out_ready_i = 1'b0;
      accepted = 0;
      rand_instr();
      for (int i = 0; i < 3; i++) begin
         tick(acc, ret);
         if (acc) begin accepted++; rand_instr(); end
      end
      check("full_in_ready", {31'd0, in_ready_o}, 32'd0);
      check("full_valid",    {31'd0, out_valid_o}, 32'd1);
      do_reset(1);
      #1;
      check("mid_rst_valid",    {31'd0, out_valid_o}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready_o}, 32'd1);
      @(negedge clk);
      out_ready_i = 1'b1;
      tick(acc, ret);
      check("mid_rst_no_emit", {31'd0, out_valid_o}, 32'd0);

      // Random traffic
      rand_instr();
      in_valid_i = 1'($urandom);
      for (int i = 0; i < 400; i++) begin
         out_ready_i = ($urandom_range(0, 3) != 0);
         tick(acc, ret);
         if (acc || !in_valid_i) begin
            rand_instr();
            in_valid_i = ($urandom_range(0, 3) != 0);
         end
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      cyc = 0;
      while (sb.size() != 0 && cyc < 10) begin
         tick(acc, ret);
         cyc++;
      end
      check("final_drain", sb.size(), 32'd0);
      check("final_idle",  {31'd0, out_valid_o}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_alu_issue
`default_nettype wire
